mux_scan_ctrl: RTL and testbench

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_ctrl.sv | 135 +++++++++++++
 tb/tb_mux_scan_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mux_scan_ctrl
// Brief   : Steps a latched 4-bit word through an external 4:1 mux, samples
//           the returned bit per select, and reports the rebuilt word.
// Rev     : 1.0
// ============================================================================
module mux_scan_ctrl #(
    parameter int DWELL = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    output logic [3:0] mux_i,
    output logic       sel_a,
    output logic       sel_b,
    input  logic       mux_out,
    output logic       ser_valid,
    output logic       ser_bit,
    output logic       ser_last,
    output logic       word_valid,
    output logic [3:0] word_data,
    output logic       word_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] c_dwell_last = 4'(DWELL - 1);

    state_t     r_state, w_state_nxt;
    logic [1:0] r_idx, w_idx_nxt;
    logic [3:0] r_dwell, w_dwell_nxt;
    logic [3:0] r_capture, w_capture_nxt;
    logic [3:0] r_mux_i;
    logic [1:0] r_sel;
    logic       r_ser_valid, r_ser_bit, r_ser_last;
    logic       r_word_valid, r_word_err;
    logic [3:0] r_word_data;
    logic       w_accept, w_sample, w_last;

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_dwell_nxt   = r_dwell;
        w_capture_nxt = r_capture;
        w_accept      = 1'b0;
        w_sample      = 1'b0;
        w_last        = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_idx_nxt   = 2'd0;
                    w_dwell_nxt = 4'd0;
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (r_dwell == c_dwell_last) begin
                    w_sample             = 1'b1;
                    w_last               = (r_idx == 2'd3);
                    w_capture_nxt[r_idx] = mux_out;
                    w_dwell_nxt          = 4'd0;
                    w_idx_nxt            = r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        w_state_nxt = DONE;
                    end
                end else begin
                    w_dwell_nxt = r_dwell + 4'd1;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_idx        <= 2'd0;
            r_dwell      <= 4'd0;
            r_capture    <= 4'd0;
            r_mux_i      <= 4'd0;
            r_sel        <= 2'd0;
            r_ser_valid  <= 1'b0;
            r_ser_bit    <= 1'b0;
            r_ser_last   <= 1'b0;
            r_word_valid <= 1'b0;
            r_word_data  <= 4'd0;
            r_word_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_dwell      <= w_dwell_nxt;
            r_capture    <= w_capture_nxt;
            r_ser_valid  <= w_sample;
            r_word_valid <= w_last;
            if (w_accept) begin
                r_mux_i <= in_data;
                r_sel   <= 2'd0;
            end
            if (w_sample) begin
                r_ser_bit  <= mux_out;
                r_ser_last <= w_last;
                // Select parks on index 3 once the word completes
                if (!w_last) begin
                    r_sel <= r_idx + 2'd1;
                end
            end
            if (w_last) begin
                r_word_data <= w_capture_nxt;
                r_word_err  <= (w_capture_nxt != r_mux_i);
            end
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign mux_i      = r_mux_i;
    assign sel_a      = r_sel[1];
    assign sel_b      = r_sel[0];
    assign ser_valid  = r_ser_valid;
    assign ser_bit    = r_ser_bit;
    assign ser_last   = r_ser_last;
    assign word_valid = r_word_valid;
    assign word_data  = r_word_data;
    assign word_err   = r_word_err;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mux_scan_ctrl
// Brief   : Runs DWELL=1 and DWELL=3 instances side by side against a
//           timeline model of the scan protocol.
// Rev     : 1.0
// ============================================================================
module tb_mux_scan_ctrl;

    logic clk = 1'b0;
    logic rst, in_valid, stuck_en, stuck_val;
    logic [3:0] in_data;

    logic [1:0]      in_ready, sel_a, sel_b, mux_out;
    logic [1:0]      ser_valid, ser_bit, ser_last, word_valid, word_err;
    logic [1:0][3:0] mux_i, word_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mux_scan_ctrl #(.DWELL(1)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_data(in_data), .mux_i(mux_i[0]), .sel_a(sel_a[0]), .sel_b(sel_b[0]),
        .mux_out(mux_out[0]), .ser_valid(ser_valid[0]), .ser_bit(ser_bit[0]),
        .ser_last(ser_last[0]), .word_valid(word_valid[0]),
        .word_data(word_data[0]), .word_err(word_err[0])
    );

    mux_scan_ctrl #(.DWELL(3)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_data(in_data), .mux_i(mux_i[1]), .sel_a(sel_a[1]), .sel_b(sel_b[1]),
        .mux_out(mux_out[1]), .ser_valid(ser_valid[1]), .ser_bit(ser_bit[1]),
        .ser_last(ser_last[1]), .word_valid(word_valid[1]),
        .word_data(word_data[1]), .word_err(word_err[1])
    );

    // Ideal mux, optionally with its output stuck
    assign mux_out[0] = stuck_en ? stuck_val : mux_i[0][{sel_a[0], sel_b[0]}];
    assign mux_out[1] = stuck_en ? stuck_val : mux_i[1][{sel_a[1], sel_b[1]}];

    function automatic int dw(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Timeline model: t counts edges since the accept edge
    bit         m_busy [2];
    int         m_t    [2];
    logic [3:0] m_word [2], m_capt[2], m_wdata[2];
    logic [1:0] m_sel  [2];
    logic       m_sv[2], m_sb[2], m_sl[2], m_wv[2], m_we[2];

    task automatic model_step(input int i);
        int   k;
        logic b;
        if (rst) begin
            m_busy[i] = 0; m_t[i] = 0; m_word[i] = 4'd0; m_capt[i] = 4'd0;
            m_sel[i] = 2'd0; m_sv[i] = 0; m_sb[i] = 0; m_sl[i] = 0;
            m_wv[i] = 0; m_wdata[i] = 4'd0; m_we[i] = 0;
        end else if (!m_busy[i]) begin
            m_sv[i] = 0; m_wv[i] = 0;
            if (in_valid) begin
                m_busy[i] = 1; m_t[i] = 0; m_word[i] = in_data; m_sel[i] = 2'd0;
            end
        end else begin
            m_t[i] = m_t[i] + 1;
            m_sv[i] = 0; m_wv[i] = 0;
            if (m_t[i] > 4 * dw(i)) begin
                m_busy[i] = 0;
            end else if (m_t[i] % dw(i) == 0) begin
                k = m_t[i] / dw(i) - 1;
                b = stuck_en ? stuck_val : m_word[i][k];
                m_capt[i][k] = b;
                m_sv[i] = 1; m_sb[i] = b; m_sl[i] = (k == 3);
                if (k == 3) begin
                    m_wv[i] = 1; m_wdata[i] = m_capt[i]; m_we[i] = (m_capt[i] != m_word[i]);
                end else begin
                    m_sel[i] = 2'(k + 1);
                end
            end
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) model_step(i);
    end

    function automatic logic [15:0] act_vec(input int i);
        return {in_ready[i], mux_i[i], sel_a[i], sel_b[i], ser_valid[i],
                word_valid[i], ser_bit[i], ser_last[i], word_data[i], word_err[i]};
    endfunction

    // Per-cycle comparison; serial/word payloads only matter under their strobes
    always @(negedge clk) begin
        logic [15:0] e, m;
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                e = {!m_busy[i], m_word[i], m_sel[i], m_sv[i], m_wv[i],
                     m_sb[i], m_sl[i], m_wdata[i], m_we[i]};
                m = {9'h1ff, m_sv[i] ? 2'b11 : 2'b00, m_wv[i] ? 5'h1f : 5'h00};
                checks++;
                if ((act_vec(i) & m) !== (e & m)) begin
                    errors++;
                    $display("FAIL cycle%0d dut%0d: got %h expected %h (mask %h)",
                             cyc, i, act_vec(i), e, m);
                end
            end
        end
    end

    logic [3:0] q0[$], q1[$];
    int wv_cyc[2];
    always @(negedge clk) begin
        if (word_valid[0] === 1'b1) begin q0.push_back(word_data[0]); wv_cyc[0] = cyc; end
        if (word_valid[1] === 1'b1) begin q1.push_back(word_data[1]); wv_cyc[1] = cyc; end
    end

    task automatic check_reset_state(input string name);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_vec(i) !== 16'h8000) begin
                errors++;
                $display("FAIL %s dut%0d: got %h expected 8000", name, i, act_vec(i));
            end
        end
    endtask

    task automatic wait_both_words(input string name);
        int n = 0;
        while ((q0.size() == 0 || q1.size() == 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (q0.size() == 0 || q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s timeout: words seen %0d/%0d required 1/1", name, q0.size(), q1.size());
        end
    endtask

    task automatic expect_eq(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    typedef struct {
        logic [3:0] din;
        bit         sten;
        bit         stv;
        logic [3:0] ew;
        bit         ee;
    } vec_t;

    vec_t vecs[6];
    int   acc_cyc;

    initial begin
        vecs[0] = '{4'b1010, 0, 0, 4'b1010, 0};
        vecs[1] = '{4'b0110, 0, 0, 4'b0110, 0};
        vecs[2] = '{4'b1111, 1, 0, 4'b0000, 1};
        vecs[3] = '{4'b0000, 1, 1, 4'b1111, 1};
        vecs[4] = '{4'b0101, 1, 1, 4'b1111, 1};
        vecs[5] = '{4'b1001, 0, 0, 4'b1001, 0};

        rst = 1'b1; in_valid = 1'b0; in_data = 4'd0; stuck_en = 1'b0; stuck_val = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_state("reset");
        chk_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 6; r++) begin
            q0.delete(); q1.delete();
            stuck_en = vecs[r].sten; stuck_val = vecs[r].stv;
            in_valid = 1'b1; in_data = vecs[r].din; acc_cyc = cyc;
            @(negedge clk);
            in_valid = 1'b0;
            wait_both_words($sformatf("vec%0d", r));
            if (q0.size() > 0 && q1.size() > 0) begin
                expect_eq($sformatf("vec%0d word dw1", r), {word_err[0], q0[0]}, {vecs[r].ee, vecs[r].ew});
                expect_eq($sformatf("vec%0d word dw3", r), {word_err[1], q1[0]}, {vecs[r].ee, vecs[r].ew});
                expect_eq($sformatf("vec%0d latency dw1", r), wv_cyc[0] - acc_cyc, 5);
                expect_eq($sformatf("vec%0d latency dw3", r), wv_cyc[1] - acc_cyc, 13);
            end
            repeat (3) @(negedge clk);
        end

        // in_valid held high: 0x3 then 0xC
        stuck_en = 1'b0;
        q0.delete(); q1.delete();
        in_valid = 1'b1; in_data = 4'h3;
        @(negedge clk);
        in_data = 4'hC;
        repeat (16) @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        expect_eq("hold dw1 count", (q0.size() >= 2) ? 1 : 0, 1);
        expect_eq("hold dw3 count", (q1.size() >= 2) ? 1 : 0, 1);
        if (q0.size() >= 2) expect_eq("hold dw1 words", {q0[0], q0[1]}, 8'h3C);
        if (q1.size() >= 2) expect_eq("hold dw3 words", {q1[0], q1[1]}, 8'h3C);

        // Reset at the second serial strobe of the DWELL=1 instance
        begin
            int sv_seen = 0;
            int n = 0;
            in_valid = 1'b1; in_data = 4'b1010;
            @(negedge clk);
            in_valid = 1'b0;
            while (sv_seen < 2 && n < 20) begin
                if (ser_valid[0] === 1'b1) sv_seen++;
                if (sv_seen < 2) begin
                    @(negedge clk);
                    n++;
                end
            end
            expect_eq("abort second strobe seen", sv_seen, 2);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check_reset_state("abort");
            q0.delete(); q1.delete();
            repeat (16) @(negedge clk);
            expect_eq("abort no words", q0.size() + q1.size(), 0);
        end

        // Reset wins over a simultaneous offer
        rst = 1'b1; in_valid = 1'b1; in_data = 4'hF;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        check_reset_state("rst_vs_valid");

        // Normal word after the aborts
        q0.delete(); q1.delete();
        in_valid = 1'b1; in_data = 4'b1010;
        @(negedge clk);
        in_valid = 1'b0;
        wait_both_words("post_abort");
        if (q0.size() > 0) expect_eq("post_abort word dw1", q0[0], 4'b1010);

        // Randomized traffic with occasional resets and stuck faults
        for (int c = 0; c < 600; c++) begin
            rst      = ($urandom_range(0, 59) == 0);
            in_valid = ($urandom_range(0, 2) == 0);
            in_data  = 4'($urandom);
            if ($urandom_range(0, 24) == 0) begin
                stuck_en  = 1'($urandom);
                stuck_val = 1'($urandom);
            end
            @(negedge clk);
        end
        rst = 1'b0; in_valid = 1'b0;
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
